cordic_dds_pipe_gen: RTL and testbench
======================================

# cordic_dds_pipe_gen

Parametrised, next-generation pipelined CORDIC direct digital synthesiser: phase accumulator, quadrant fold, STAGES-deep rotation pipeline and quadrant restore, producing quadrature sin/cos each enabled cycle. It replaces the fixed 16-bit sine-only DDS chain in the signal-generation path. New behaviour:
- Cosine output.
- Double-buffered frequency/phase update with optional accumulator clear.
- Writable arctangent table that flushes the valid flag.
- Output saturation.

## Interface
Parameters:
- PHASE_W, 16: phase accumulator / angle width, full turn = 2^PHASE_W.
- AMP_W, 16: signed output width.
- STAGES, 12: CORDIC iterations, one pipeline stage each. Legal range 4..PHASE_W-2.
- X0, 19895: initial x value, cordic-gain-compensated amplitude, AMP_W-scaled.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- cen  in  1  pipeline enable. Low = every register except the table holds.
- fcw  in  PHASE_W  frequency control word (shadow).
- phase_off  in  PHASE_W  phase offset (shadow).
- upd  in  1  copy fcw/phase_off into active registers.
- acc_clr  in  1  with upd: also zero the accumulator.
- tbl_we  in  1  atan table write strobe.
- tbl_addr  in  $clog2(STAGES)  table index i.
- tbl_data  in  PHASE_W  atan(2^-i) in phase units.
- sin_out  out  AMP_W  signed sine.
- cos_out  out  AMP_W  signed cosine.
- valid  out  1  outputs correspond to current table and settled pipeline.

## Operation
- Reset state: acc=0, fcw_act=0, off_act=0, all pipeline registers 0, sin_out=0, cos_out=0, valid=0, fill counter=0.
- Reset loads the table with defaults round(atan(2^-i)/2π·2^PHASE_W). For PHASE_W=16 these start 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5.
- Active update: upd=1 in a cycle loads fcw_act/off_act at that edge, independent of cen. If acc_clr=1 in the same cycle, acc is zeroed at that edge instead of accumulating. acc_clr without upd is ignored.
- Accumulator: when cen=1, acc <= acc + fcw_act, modulo 2^PHASE_W. Wrap-around is silent.
- Fold stage (registered): p = acc + off_act, modulo 2^PHASE_W.
  - q = p[PHASE_W-1:PHASE_W-2].
  - z0 = {2'b00, p[PHASE_W-3:0]}, i.e. angle in [0, 90°).
  - x0 = X0, y0 = 0.
  - q is carried down the pipe.
- CORDIC stage i, rotation mode, internal signed width AMP_W+2, arithmetic shift:
  - If z ≥ 0: x -= y>>>i, y += x>>>i, z -= tbl[i].
  - Otherwise the opposite signs.
- Restore and output stage, by q:
  - q=0: (cos, sin) = (x, y).
  - q=1: (−y, x).
  - q=2: (−x, −y).
  - q=3: (y, −x).
  - Results are saturated to ±(2^(AMP_W-1)−1). −2^(AMP_W-1) is never produced.
- Table write: tbl_we=1 with tbl_addr<STAGES writes at the edge, independent of cen. The new value is used by samples passing stage i from the next cycle. The write clears the fill counter, so valid=0 next cycle. tbl_addr≥STAGES is ignored, with no flush.
- valid: the fill counter increments on each cen=1 cycle, saturating at STAGES+2. valid=1 iff counter=STAGES+2. upd does not clear valid.

## Timing
- Latency: an acc value registered at edge n appears on sin_out/cos_out STAGES+2 enabled edges later. The path is fold (1) + STAGES + output (1).
- The first valid=1 is the (STAGES+2)th cen=1 edge after reset release. With STAGES=12, that is the 14th enabled cycle.
- cen=0 freezes sin_out, cos_out, valid and the counter. Table writes and upd still act.
- upd effect: the first sample using the new fcw_act is the acc update at the edge after the upd edge. That sample reaches the output STAGES+2 enabled cycles later. With acc_clr, the output sequence restarts from phase off_act.
- Simultaneous events:
  - reset overrides everything.
  - tbl_we and upd in the same cycle: both take effect.
  - tbl_we during cen=0: counter cleared, refill on later cen=1 cycles.
- Accuracy: |error| ≤ 2^(PHASE_W−STAGES)·2π/2^PHASE_W·A + 4 LSB, where A = 2^(AMP_W−1)−1.

## Test plan
- Reset, with defaults: fcw=0, phase_off=0, upd pulse, cen=1 held. Response: valid rises on the 14th enabled edge; cos_out ≈ 32767 (±8), sin_out ≈ 0 (±8); before that, outputs are 0 and valid=0.
- Quadrant sweep: fcw=16384, upd with acc_clr. Response: after latency, cos/sin cycle (+A,0), (0,+A), (−A,0), (0,−A) in every 4 samples, ±8 LSB; accumulator wrap is seamless.
- Offset hop: running at fcw=1024, then upd with phase_off=16384 and no clear. Response: exactly STAGES+2 cycles later the output phase jumps 90°, with sin_new ≈ previous-trend cos.
- Stall: toggle cen 0/1 pseudo-randomly at fcw=4096. Response: output sequence is identical to the cen=1 reference, just stretched; outputs hold when cen=0.
- Table write: write tbl[0]=0 mid-run. Response: valid=0 next cycle, high again after 14 enabled edges; at phase 45° the output deviates from ideal by more than 1000 LSB, confirming the table is used. tbl_addr=12 write: no flush.
- Saturation: X0 overridden to 32767 via parameter, phase 0. Response: cos_out clamps to 32767 and never wraps negative.

Source files
------------

// File: rtl/cordic_dds_pipe_gen_if.sv
// cordic_dds_pipe_gen_if: control, table-write and output bundle
// for the pipelined CORDIC DDS.
interface cordic_dds_pipe_gen_if #(
  parameter int PHASE_W = 16,
  parameter int AMP_W   = 16,
  parameter int STAGES  = 12
);
  localparam int TW = $clog2(STAGES);

  logic                      cen;
  logic [PHASE_W-1:0]        fcw;
  logic [PHASE_W-1:0]        phase_off;
  logic                      upd;
  logic                      acc_clr;
  logic                      tbl_we;
  logic [TW-1:0]             tbl_addr;
  logic [PHASE_W-1:0]        tbl_data;
  logic signed [AMP_W-1:0]   sin_out;
  logic signed [AMP_W-1:0]   cos_out;
  logic                      valid;

  modport master (
    output cen, fcw, phase_off, upd, acc_clr,
    output tbl_we, tbl_addr, tbl_data,
    input  sin_out, cos_out, valid
  );

  modport slave (
    input  cen, fcw, phase_off, upd, acc_clr,
    input  tbl_we, tbl_addr, tbl_data,
    output sin_out, cos_out, valid
  );
endinterface

// File: rtl/cordic_dds_pipe_gen.sv
// cordic_dds_pipe_gen: phase accumulator, quadrant fold, STAGES-deep
// CORDIC rotation pipe and quadrant restore with output saturation.
module cordic_dds_pipe_gen #(
  parameter int PHASE_W = 16,
  parameter int AMP_W   = 16,
  parameter int STAGES  = 12,
  parameter int X0      = 19895
) (
  input logic                  clk,
  input logic                  reset,
  cordic_dds_pipe_gen_if.slave bus
);
  localparam int XW = AMP_W + 2;
  localparam int OW = AMP_W + 3;
  localparam int CW = $clog2(STAGES + 3);
  localparam logic [CW-1:0] CMAX = CW'(STAGES + 2);
  localparam logic signed [XW-1:0] X0_S = XW'(X0);
  localparam logic signed [OW-1:0] SMAX =
    OW'((2 ** (AMP_W - 1)) - 1);

  // Elaboration-time atan(2^-i) in phase units, packed by index.
  function automatic logic [STAGES*PHASE_W-1:0] atan_tbl();
    logic [STAGES*PHASE_W-1:0] r;
    real x, t, s, turn;
    r = '0;
    turn = 1.0;
    for (int k = 0; k < PHASE_W; k++) turn = turn * 2.0;
    for (int i = 0; i < STAGES; i++) begin
      x = 1.0;
      for (int k = 0; k < i; k++) x = x / 2.0;
      s = 0.0;
      t = x;
      for (int k = 0; k < 60; k++) begin
        if (k % 2 == 0) s = s + t / real'(2 * k + 1);
        else            s = s - t / real'(2 * k + 1);
        t = t * x * x;
      end
      if (i == 0) s = 0.7853981633974483;
      r[i*PHASE_W +: PHASE_W] =
        PHASE_W'($rtoi(s / 6.283185307179586 * turn + 0.5));
    end
    return r;
  endfunction

  localparam logic [STAGES*PHASE_W-1:0] ATAN0 = atan_tbl();

  function automatic logic signed [AMP_W-1:0] sat(
    input logic signed [OW-1:0] v
  );
    if (v > SMAX)  return AMP_W'(SMAX);
    if (v < -SMAX) return AMP_W'(-SMAX);
    return AMP_W'(v);
  endfunction

  logic [PHASE_W-1:0]        acc_q, acc_d;
  logic [PHASE_W-1:0]        fcw_q, off_q;
  logic [PHASE_W-1:0]        tbl_q [STAGES];
  logic signed [XW-1:0]      x_q [STAGES+1];
  logic signed [XW-1:0]      x_d [STAGES+1];
  logic signed [XW-1:0]      y_q [STAGES+1];
  logic signed [XW-1:0]      y_d [STAGES+1];
  logic signed [PHASE_W-1:0] z_q [STAGES+1];
  logic signed [PHASE_W-1:0] z_d [STAGES+1];
  logic [1:0]                q_q [STAGES+1];
  logic [1:0]                q_d [STAGES+1];
  logic signed [AMP_W-1:0]   cos_q, cos_d;
  logic signed [AMP_W-1:0]   sin_q, sin_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [PHASE_W-1:0]        ph;
  logic                      tbl_wr;
  logic signed [OW-1:0]      xe, ye, c_w, s_w;

  assign ph     = acc_q + off_q;
  assign tbl_wr = bus.tbl_we &&
                  (int'(bus.tbl_addr) < STAGES);

  always_comb begin
    acc_d = acc_q;
    if (bus.upd && bus.acc_clr) acc_d = '0;
    else if (bus.cen)           acc_d = acc_q + fcw_q;
    cnt_d = cnt_q;
    if (tbl_wr)                          cnt_d = '0;
    else if (bus.cen && cnt_q != CMAX)   cnt_d = cnt_q + 1'b1;
  end

  // Fold to [0, 90deg) and run the rotation recurrences.
  always_comb begin
    x_d[0] = X0_S;
    y_d[0] = '0;
    z_d[0] = {2'b00, ph[PHASE_W-3:0]};
    q_d[0] = ph[PHASE_W-1 -: 2];
    for (int i = 0; i < STAGES; i++) begin
      if (!z_q[i][PHASE_W-1]) begin
        x_d[i+1] = x_q[i] - (y_q[i] >>> i);
        y_d[i+1] = y_q[i] + (x_q[i] >>> i);
        z_d[i+1] = z_q[i] - $signed(tbl_q[i]);
      end else begin
        x_d[i+1] = x_q[i] + (y_q[i] >>> i);
        y_d[i+1] = y_q[i] - (x_q[i] >>> i);
        z_d[i+1] = z_q[i] + $signed(tbl_q[i]);
      end
      q_d[i+1] = q_q[i];
    end
  end

  always_comb begin
    xe = OW'(x_q[STAGES]);
    ye = OW'(y_q[STAGES]);
    c_w = xe;
    s_w = ye;
    unique case (q_q[STAGES])
      2'd0: begin c_w = xe;  s_w = ye;  end
      2'd1: begin c_w = -ye; s_w = xe;  end
      2'd2: begin c_w = -xe; s_w = -ye; end
      2'd3: begin c_w = ye;  s_w = -xe; end
    endcase
    cos_d = sat(c_w);
    sin_d = sat(s_w);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      fcw_q <= '0;
      off_q <= '0;
      cos_q <= '0;
      sin_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < STAGES; i++)
        tbl_q[i] <= ATAN0[i*PHASE_W +: PHASE_W];
      for (int i = 0; i <= STAGES; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        z_q[i] <= '0;
        q_q[i] <= '0;
      end
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      if (bus.upd) begin
        fcw_q <= bus.fcw;
        off_q <= bus.phase_off;
      end
      if (tbl_wr) tbl_q[bus.tbl_addr] <= bus.tbl_data;
      if (bus.cen) begin
        for (int i = 0; i <= STAGES; i++) begin
          x_q[i] <= x_d[i];
          y_q[i] <= y_d[i];
          z_q[i] <= z_d[i];
          q_q[i] <= q_d[i];
        end
        cos_q <= cos_d;
        sin_q <= sin_d;
      end
    end
  end

  assign bus.cos_out = cos_q;
  assign bus.sin_out = sin_q;
  assign bus.valid   = (cnt_q == CMAX);
endmodule

// File: tb/tb_cordic_dds_pipe_gen.sv
// tb_cordic_dds_pipe_gen: directed steps against a scoreboard fed by
// an independent per-sample CORDIC reference and accumulator model.
module tb_cordic_dds_pipe_gen;
  localparam int ST  = 12;
  localparam int LAT = ST + 1;
  localparam int A   = 32767;
  localparam int ACC_TOL = 54;
  localparam int DEF_T [ST] = '{8192, 4836, 2555, 1297, 651, 326,
                                163, 81, 41, 20, 10, 5};

  typedef struct {
    int due;
    int c;
    int s;
    int p;
    bit ok;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cordic_dds_pipe_gen_if #(.PHASE_W(16), .AMP_W(16), .STAGES(ST)) bus ();
  cordic_dds_pipe_gen_if #(.PHASE_W(16), .AMP_W(16), .STAGES(ST)) sbus ();

  cordic_dds_pipe_gen #(
    .PHASE_W(16), .AMP_W(16), .STAGES(ST), .X0(19895)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  cordic_dds_pipe_gen #(
    .PHASE_W(16), .AMP_W(16), .STAGES(ST), .X0(32767)
  ) u_sat (.clk(clk), .reset(reset), .bus(sbus));

  int errs = 0;
  int checks = 0;
  int acc_m, fcw_m, off_m, cnt_m, ecnt;
  int tbl_m [ST];
  int last_c, last_s;
  bit last_ok;
  bit tbl_dflt;
  exp_t sb [$];

  function automatic int sat(input int v);
    if (v > A)  return A;
    if (v < -A) return -A;
    return v;
  endfunction

  function automatic void cordic_ref(input int p, input int x0,
                                     output int c, output int s);
    int x, y, z, xs, ys, q;
    q = (p >> 14) & 3;
    z = p & 16383;
    x = x0;
    y = 0;
    for (int i = 0; i < ST; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (z >= 0) begin
        x = x - ys; y = y + xs; z = z - tbl_m[i];
      end else begin
        x = x + ys; y = y - xs; z = z + tbl_m[i];
      end
    end
    case (q)
      0:       begin c = x;  s = y;  end
      1:       begin c = -y; s = x;  end
      2:       begin c = -x; s = -y; end
      default: begin c = y;  s = -x; end
    endcase
    c = sat(c);
    s = sat(s);
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: got %0d want %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs,
                         input int expv, input int tol);
    checks++;
    assert ((obs - expv) <= tol && (expv - obs) <= tol) else begin
      errs++;
      $error("FAIL %s: got %0d want %0d+-%0d", tag, obs, expv, tol);
    end
  endtask

  task automatic model_reset();
    acc_m = 0; fcw_m = 0; off_m = 0; cnt_m = 0; ecnt = 0;
    for (int k = 0; k < ST; k++) tbl_m[k] = DEF_T[k];
    tbl_dflt = 1'b1;
    sb.delete();
    for (int k = 1; k <= LAT; k++) sb.push_back('{k, 0, 0, -1, 1'b1});
    last_c = 0; last_s = 0; last_ok = 1'b1;
  endtask

  task automatic step();
    exp_t e;
    bit en, we;
    int p, c, s, ad;
    @(posedge clk);
    en = bus.cen;
    ad = int'(bus.tbl_addr);
    we = bus.tbl_we && ad < ST;
    if (reset) begin
      model_reset();
    end else begin
      if (we) begin
        foreach (sb[k]) sb[k].ok = 1'b0;
        tbl_m[ad] = int'(bus.tbl_data);
        tbl_dflt = 1'b1;
        for (int k = 0; k < ST; k++)
          if (tbl_m[k] != DEF_T[k]) tbl_dflt = 1'b0;
      end
      if (en) begin
        ecnt++;
        p = (acc_m + off_m) & 16'hFFFF;
        cordic_ref(p, 19895, c, s);
        sb.push_back('{ecnt + LAT, c, s, p, 1'b1});
      end
      if (we) cnt_m = 0;
      else if (en && cnt_m < ST + 2) cnt_m++;
      if (bus.upd && bus.acc_clr) acc_m = 0;
      else if (en) acc_m = (acc_m + fcw_m) & 16'hFFFF;
      if (bus.upd) begin
        fcw_m = int'(bus.fcw);
        off_m = int'(bus.phase_off);
      end
    end
    #1;
    if (reset) begin
      chk("rst_cos", int'(bus.cos_out), 0);
      chk("rst_sin", int'(bus.sin_out), 0);
      chk("rst_valid", int'(bus.valid), 0);
    end else begin
      chk("valid", int'(bus.valid), (cnt_m == ST + 2) ? 1 : 0);
      if (en) begin
        if (sb.size() == 0 || sb[0].due != ecnt) begin
          chk("sb_align", ecnt, (sb.size() == 0) ? -1 : sb[0].due);
        end else begin
          e = sb.pop_front();
          last_ok = e.ok;
          if (e.ok) begin
            last_c = e.c;
            last_s = e.s;
            chk("cos", int'(bus.cos_out), e.c);
            chk("sin", int'(bus.sin_out), e.s);
            if (tbl_dflt && e.p >= 0 && (e.p & 16383) == 0) begin
              case (e.p >> 14)
                0: begin c = A;  s = 0;  end
                1: begin c = 0;  s = A;  end
                2: begin c = -A; s = 0;  end
                default: begin c = 0; s = -A; end
              endcase
              chk_tol("cos_ideal", int'(bus.cos_out), c, ACC_TOL);
              chk_tol("sin_ideal", int'(bus.sin_out), s, ACC_TOL);
            end
          end
        end
      end else if (last_ok) begin
        chk("hold_cos", int'(bus.cos_out), last_c);
        chk("hold_sin", int'(bus.sin_out), last_s);
      end
    end
  endtask

  task automatic upd_pulse(input int f, input int off, input bit clr);
    bus.fcw = 16'(f);
    bus.phase_off = 16'(off);
    bus.upd = 1'b1;
    bus.acc_clr = clr;
    step();
    bus.upd = 1'b0;
    bus.acc_clr = 1'b0;
  endtask

  task automatic tbl_write(input int ad, input int d);
    bus.tbl_we = 1'b1;
    bus.tbl_addr = 4'(ad);
    bus.tbl_data = 16'(d);
    step();
    bus.tbl_we = 1'b0;
  endtask

  int dev;

  initial begin
    reset = 1'b1;
    bus.cen = 1'b0; bus.fcw = '0; bus.phase_off = '0;
    bus.upd = 1'b0; bus.acc_clr = 1'b0; bus.tbl_we = 1'b0;
    bus.tbl_addr = '0; bus.tbl_data = '0;
    sbus.cen = 1'b0; sbus.fcw = '0; sbus.phase_off = '0;
    sbus.upd = 1'b0; sbus.acc_clr = 1'b0; sbus.tbl_we = 1'b0;
    sbus.tbl_addr = '0; sbus.tbl_data = '0;
    repeat (3) step();

    // reset release, dc output, valid rises on 14th enabled edge
    reset = 1'b0;
    bus.cen = 1'b1;
    sbus.cen = 1'b1;
    sbus.upd = 1'b1;
    upd_pulse(0, 0, 1'b0);
    sbus.upd = 1'b0;
    repeat (20) step();

    // quadrant sweep with accumulator clear and wrap
    upd_pulse(16384, 0, 1'b1);
    repeat (24) step();

    // offset hop without clear
    upd_pulse(1024, 0, 1'b1);
    repeat (20) step();
    upd_pulse(1024, 16384, 1'b0);
    repeat (20) step();

    // pseudo-random stall
    upd_pulse(4096, 0, 1'b1);
    repeat (80) begin
      bus.cen = 1'($urandom_range(0, 1));
      step();
    end
    bus.cen = 1'b1;
    repeat (16) step();

    // table write: zero tbl[0], observe flush, refill, 45deg deviation
    upd_pulse(2048, 0, 1'b1);
    repeat (5) step();
    tbl_write(0, 0);
    repeat (14) step();
    upd_pulse(0, 8192, 1'b1);
    repeat (15) step();
    dev = int'(bus.cos_out) - 23170;
    checks++;
    assert (dev > 1000 || dev < -1000) else begin
      errs++;
      $error("FAIL tbl_used: cos %0d want far from 23170", bus.cos_out);
    end
    tbl_write(12, 123);
    tbl_write(0, 8192);
    repeat (15) step();

    // table write while stalled, then refill
    bus.cen = 1'b0;
    step();
    tbl_write(1, 4836);
    step();
    bus.cen = 1'b1;
    upd_pulse(16384, 0, 1'b1);
    repeat (16) step();

    // saturation instance: phase 0 then phase 180deg
    for (int k = 0; k < 4; k++) begin
      chk("sat_cos_pos", int'(sbus.cos_out), A);
      step();
    end
    chk("sat_valid", int'(sbus.valid), 1);
    sbus.phase_off = 16'd32768;
    sbus.upd = 1'b1;
    step();
    sbus.upd = 1'b0;
    repeat (15) step();
    chk("sat_cos_neg", int'(sbus.cos_out), -A);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
